serial_word_rx: RTL and testbench

- Downstream stage for the left-shift register. Consumes its MSB-first serial bit stream (the register's q[DW-1]) and detects a start bit.
- Reassembles DW data bits into a parallel word and checks an optional even-parity bit.
- Presents each word on a single-entry valid/ready output register, with parity-error and sticky overrun reporting.

---
 rtl/serial_word_rx.sv | 122 ++++++++++++
 tb/tb_serial_word_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - serial frame receiver: start-bit detect, MSB-first word assembly,
// even-parity check and a single-entry valid/ready output slot with sticky overrun.
module serial_word_rx #(
    parameter int DW        = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          sin,
    input  logic          sin_vld,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          par_err,
    output logic          ovr_err,
    output logic          busy
);
    localparam int CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          par_err_q, par_err_d;
    logic          ovr_err_q, ovr_err_d;
    logic          busy_q;
    logic          done;
    logic [DW-1:0] word;
    logic          perr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        word    = shreg_q;
        perr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sin_vld && sin) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (sin_vld) begin
                    shreg_d = {shreg_q[DW-2:0], sin};
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (PARITY_EN) begin
                            state_d = PARITY;
                        end else begin
                            state_d = IDLE;
                            done    = 1'b1;
                            word    = {shreg_q[DW-2:0], sin};
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (sin_vld) begin
                    state_d = IDLE;
                    done    = 1'b1;
                    word    = shreg_q;
                    perr    = (^shreg_q) ^ sin;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completion may refill the slot on the same edge the consumer drains it.
    always_comb begin
        dout_d     = dout_q;
        par_err_d  = par_err_q;
        dout_vld_d = dout_vld_q && !dout_rdy;
        ovr_err_d  = ovr_err_q;
        if (done) begin
            if (!dout_vld_q || dout_rdy) begin
                dout_d     = word;
                par_err_d  = perr;
                dout_vld_d = 1'b1;
            end else begin
                ovr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            par_err_q  <= par_err_d;
            ovr_err_q  <= ovr_err_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign par_err  = par_err_q;
    assign ovr_err  = ovr_err_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - directed and randomized checks of serial_word_rx against a frame-level model.
module tb_serial_word_rx;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          sync_rst = 1'b0;
    logic          sin = 1'b0;
    logic          sin_vld = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy = 1'b0;
    logic          par_err;
    logic          ovr_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    serial_word_rx #(.DW(DW), .PARITY_EN(1'b1)) dut (
        .clk(clk), .sync_rst(sync_rst), .sin(sin), .sin_vld(sin_vld),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .par_err(par_err), .ovr_err(ovr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        sin = b;
        sin_vld = 1'b1;
        tick();
        sin_vld = 1'b0;
        sin = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    // Sends start bit, data MSB first and the given parity bit; no gaps.
    task automatic send_frame(input logic [DW-1:0] w, input logic p);
        send_bit(1'b1, 0);
        for (int i = DW - 1; i >= 0; i--) send_bit(w[i], 0);
        send_bit(p, 0);
    endtask

    function automatic logic ref_perr(input logic [DW-1:0] w, input logic p);
        int ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(w[i]);
        ones += int'(p);
        return (ones % 2) != 0;
    endfunction

    task automatic do_reset();
        sync_rst = 1'b1;
        sin_vld = 1'b0;
        dout_rdy = 1'b0;
        tick();
        sync_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout !== '0)      begin errors++; $display("FAIL reset_dout got=%b exp=0000", dout); end
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", dout_vld); end
        checks++; if (par_err !== 1'b0)  begin errors++; $display("FAIL reset_perr got=%b exp=0", par_err); end
        checks++; if (ovr_err !== 1'b0)  begin errors++; $display("FAIL reset_ovr got=%b exp=0", ovr_err); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic(input logic p, input string nm);
        logic [DW-1:0] w = 4'b1011;
        do_reset();
        send_bit(1'b1, 0);
        for (int i = DW - 1; i >= 0; i--) send_bit(w[i], 0);
        checks++; if (dout_vld !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL %s_prefinal vld=%b busy=%b exp vld=0 busy=1", nm, dout_vld, busy); end
        send_bit(p, 0);
        checks++; if (dout_vld !== 1'b1) begin errors++; $display("FAIL %s_vld got=%b exp=1", nm, dout_vld); end
        checks++; if (dout !== w) begin errors++; $display("FAIL %s_dout got=%b exp=%b", nm, dout, w); end
        checks++; if (par_err !== ref_perr(w, p)) begin errors++;
            $display("FAIL %s_perr got=%b exp=%b", nm, par_err, ref_perr(w, p)); end
        checks++; if (ovr_err !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL %s_ovr_busy ovr=%b busy=%b exp 0 0", nm, ovr_err, busy); end
        dout_rdy = 1'b1;
        tick();
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL %s_drain got=%b exp=0", nm, dout_vld); end
        dout_rdy = 1'b0;
    endtask

    task automatic test_gaps();
        logic [DW-1:0] w = 4'b0100;
        logic p = 1'b1;
        logic [5:0] bits;
        int busy_bad = 0;
        bits = {1'b1, w, p};
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            sin = bits[i];
            sin_vld = 1'b1;
            tick();
            sin_vld = 1'b0;
            if (i != 0) for (int g = 0; g < 3; g++) begin
                if (busy !== 1'b1) busy_bad++;
                tick();
            end
        end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL gaps_busy dropped=%0d exp=0", busy_bad); end
        checks++; if (dout_vld !== 1'b1 || dout !== w) begin errors++;
            $display("FAIL gaps_word vld=%b dout=%b exp vld=1 dout=%b", dout_vld, dout, w); end
        checks++; if (par_err !== ref_perr(w, p)) begin errors++;
            $display("FAIL gaps_perr got=%b exp=%b", par_err, ref_perr(w, p)); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(4'b0011, 1'b0);
        send_frame(4'b1111, 1'b0);
        checks++; if (dout !== 4'b0011 || dout_vld !== 1'b1) begin errors++;
            $display("FAIL ovr_hold dout=%b vld=%b exp dout=0011 vld=1", dout, dout_vld); end
        checks++; if (ovr_err !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", ovr_err); end
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
        checks++; if (dout_vld !== 1'b0 || ovr_err !== 1'b1) begin errors++;
            $display("FAIL ovr_drain vld=%b ovr=%b exp vld=0 ovr=1", dout_vld, ovr_err); end
        tick();
        checks++; if (ovr_err !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", ovr_err); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] b = 4'b1110;
        do_reset();
        send_frame(4'b0011, 1'b0);
        send_bit(1'b1, 0);
        for (int i = DW - 1; i >= 0; i--) send_bit(b[i], 0);
        dout_rdy = 1'b1;
        send_bit(1'b1, 0);
        dout_rdy = 1'b0;
        checks++; if (dout_vld !== 1'b1 || dout !== b) begin errors++;
            $display("FAIL b2b_reload vld=%b dout=%b exp vld=1 dout=%b", dout_vld, dout, b); end
        checks++; if (ovr_err !== 1'b0 || par_err !== ref_perr(b, 1'b1)) begin errors++;
            $display("FAIL b2b_flags ovr=%b perr=%b exp ovr=0 perr=%b", ovr_err, par_err, ref_perr(b, 1'b1)); end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] w = 4'b0110;
        do_reset();
        send_frame(4'b1001, 1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        checks++; if (busy !== 1'b0 || dout_vld !== 1'b0) begin errors++;
            $display("FAIL midrst_state busy=%b vld=%b exp 0 0", busy, dout_vld); end
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_zeros busy=%b exp=0", busy); end
        send_frame(w, 1'b0);
        checks++; if (dout_vld !== 1'b1 || dout !== w || par_err !== ref_perr(w, 1'b0)) begin errors++;
            $display("FAIL midrst_fresh vld=%b dout=%b perr=%b exp 1 %b %b", dout_vld, dout, par_err, w, ref_perr(w, 1'b0)); end
    endtask

    // Frame-level model: one output slot, sticky overrun; updated once per clock.
    logic          m_vld;
    logic [DW-1:0] m_word;
    logic          m_perr;
    logic          m_ovr;

    task automatic rcycle(input logic b, input logic v, input logic fin,
                          input logic [DW-1:0] w, input logic pe);
        logic rdy;
        rdy = 1'($urandom_range(0, 2) == 0);
        dout_rdy = rdy;
        sin = b;
        sin_vld = v;
        checks++; if (dout_vld !== m_vld || ovr_err !== m_ovr) begin errors++;
            $display("FAIL rand_flags vld=%b ovr=%b exp vld=%b ovr=%b", dout_vld, ovr_err, m_vld, m_ovr); end
        if (m_vld) begin
            checks++; if (dout !== m_word || par_err !== m_perr) begin errors++;
                $display("FAIL rand_word dout=%b perr=%b exp dout=%b perr=%b", dout, par_err, m_word, m_perr); end
        end
        tick();
        if (fin) begin
            if (!m_vld || rdy) begin
                m_vld = 1'b1; m_word = w; m_perr = pe;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        sin_vld = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] w;
        logic p;
        logic [DW+1:0] bits;
        do_reset();
        m_vld = 1'b0; m_word = '0; m_perr = 1'b0; m_ovr = 1'b0;
        for (int f = 0; f < 40; f++) begin
            w = DW'($urandom);
            p = 1'($urandom);
            bits = {1'b1, w, p};
            for (int z = 0; z < int'($urandom_range(0, 2)); z++)
                rcycle(1'b0, 1'b1, 1'b0, w, 1'b0);
            for (int i = DW + 1; i >= 0; i--) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                    rcycle(1'($urandom), 1'b0, 1'b0, w, 1'b0);
                rcycle(bits[i], 1'b1, i == 0, w, ref_perr(w, p));
            end
        end
        for (int k = 0; k < 6; k++) rcycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        dout_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic(1'b1, "basic");
        test_basic(1'b0, "perr");
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
